// File: rtl/stream_extremum_pkg.sv
// Shared types and constants for the stream_extremum frame min/max tracker.
// Holds the FSM state encoding and the index-width derivation.
package stream_extremum_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FIRST = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_LEN   = 8;

    function automatic int calc_idx_w(input int len);
        int w;
        w = $clog2(len);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/stream_extremum_compare.sv
// Combinational unsigned magnitude compare of x against y.
// Exactly one of gt/eq/lt is high for any input pair.
module magnitude_compare #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_x,
    input  logic [WIDTH-1:0] i_y,
    output logic             o_gt,
    output logic             o_eq,
    output logic             o_lt
);

    assign o_gt = (i_x > i_y);
    assign o_eq = (i_x == i_y);
    assign o_lt = (i_x < i_y);

endmodule

// File: rtl/stream_extremum.sv
// Frame-based running max/min tracker with indices and a done pulse.
// Define STREAM_EXTREMUM_TIE_LAST_EN to make ties move the index to the last occurrence.
module stream_extremum
    import stream_extremum_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    parameter  int LEN   = DEF_LEN,
    localparam int IDX_W = calc_idx_w(LEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic [WIDTH-1:0] max_out,
    output logic [WIDTH-1:0] min_out,
    output logic [IDX_W-1:0] max_idx,
    output logic [IDX_W-1:0] min_idx,
    output logic             busy,
    output logic             done
);

    localparam logic [IDX_W:0] LEN_C = (IDX_W + 1)'(LEN);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W:0]   r_cnt;
    logic [IDX_W:0]   w_cnt_nxt;
    logic [WIDTH-1:0] r_max;
    logic [WIDTH-1:0] r_min;
    logic [IDX_W-1:0] r_max_idx;
    logic [IDX_W-1:0] r_min_idx;
    logic             w_accept;
    logic             w_max_gt;
    logic             w_max_eq;
    logic             w_max_lt;
    logic             w_min_gt;
    logic             w_min_eq;
    logic             w_min_lt;

    magnitude_compare #(.WIDTH(WIDTH)) u_cmp_max (
        .i_x  (in_data),
        .i_y  (r_max),
        .o_gt (w_max_gt),
        .o_eq (w_max_eq),
        .o_lt (w_max_lt)
    );

    magnitude_compare #(.WIDTH(WIDTH)) u_cmp_min (
        .i_x  (in_data),
        .i_y  (r_min),
        .o_gt (w_min_gt),
        .o_eq (w_min_eq),
        .o_lt (w_min_lt)
    );

    assign w_accept  = in_valid && in_ready;
    assign w_cnt_nxt = r_cnt + {{IDX_W{1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (start) w_state_nxt = ST_FIRST;
            end
            ST_FIRST: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (w_accept) w_state_nxt = (LEN == 1) ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (w_accept && (w_cnt_nxt == LEN_C)) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Max and min are tracked independently; the lt/gt opposites are unused.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_max     <= '0;
            r_min     <= '0;
            r_max_idx <= '0;
            r_min_idx <= '0;
        end else if (w_accept && (r_state == ST_FIRST)) begin
            r_cnt     <= {{IDX_W{1'b0}}, 1'b1};
            r_max     <= in_data;
            r_min     <= in_data;
            r_max_idx <= '0;
            r_min_idx <= '0;
        end else if (w_accept) begin
            r_cnt <= w_cnt_nxt;
            if (w_max_gt) begin
                r_max     <= in_data;
                r_max_idx <= r_cnt[IDX_W-1:0];
            end
`ifdef STREAM_EXTREMUM_TIE_LAST_EN
            else if (w_max_eq) begin
                r_max_idx <= r_cnt[IDX_W-1:0];
            end
`endif
            if (w_min_lt) begin
                r_min     <= in_data;
                r_min_idx <= r_cnt[IDX_W-1:0];
            end
`ifdef STREAM_EXTREMUM_TIE_LAST_EN
            else if (w_min_eq) begin
                r_min_idx <= r_cnt[IDX_W-1:0];
            end
`endif
        end
    end

    logic w_unused;
    assign w_unused = w_max_lt ^ w_min_gt ^ w_max_eq ^ w_min_eq;

    assign max_out = r_max;
    assign min_out = r_min;
    assign max_idx = r_max_idx;
    assign min_idx = r_min_idx;

endmodule
